// File: rtl/dec_reg_file.sv
// Register file of 2^AW words with one-hot decoded write select, per-word
// written flags and two independent registered read ports with write-through.
module dec_reg_file #(
  parameter int               WIDTH     = 8,
  parameter int               AW        = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclr,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [WIDTH-1:0]     wdata,
  output logic [(1<<AW)-1:0]   wsel,
  input  logic                 re_a,
  input  logic [AW-1:0]        raddr_a,
  output logic [WIDTH-1:0]     rdata_a,
  output logic                 rvalid_a,
  output logic                 rhit_a,
  input  logic                 re_b,
  input  logic [AW-1:0]        raddr_b,
  output logic [WIDTH-1:0]     rdata_b,
  output logic                 rvalid_b,
  output logic                 rhit_b
);

  localparam int NREG = 1 << AW;

  logic [WIDTH-1:0] w_word [NREG];
  logic [NREG-1:0]  w_flag;

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : gen_word
      logic [WIDTH-1:0] r_word;
      logic             r_flag;

      // Decode is deliberately independent of sclr/rst_n so it can be observed raw.
      assign wsel[gi] = we && (waddr == AW'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_word <= RESET_VAL;
          r_flag <= 1'b0;
        end else if (sclr) begin
          r_word <= RESET_VAL;
          r_flag <= 1'b0;
        end else if (wsel[gi]) begin
          r_word <= wdata;
          r_flag <= 1'b1;
        end
      end

      assign w_word[gi] = r_word;
      assign w_flag[gi] = r_flag;
    end
  endgenerate

  logic [1:0]       w_re;
  logic [AW-1:0]    w_raddr [2];
  logic [WIDTH-1:0] w_rdata [2];
  logic [1:0]       w_rvalid;
  logic [1:0]       w_rhit;

  assign w_re       = {re_b, re_a};
  assign w_raddr[0] = raddr_a;
  assign w_raddr[1] = raddr_b;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_port
      logic [WIDTH-1:0] r_rdata;
      logic             r_rvalid;
      logic             r_rhit;
      logic             w_bypass;

      // A same-cycle write to the read address returns the new data.
      assign w_bypass = we && (waddr == w_raddr[gi]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rdata  <= '0;
          r_rvalid <= 1'b0;
          r_rhit   <= 1'b0;
        end else if (sclr) begin
          r_rdata  <= '0;
          r_rvalid <= 1'b0;
          r_rhit   <= 1'b0;
        end else begin
          r_rvalid <= w_re[gi];
          if (w_re[gi]) begin
            if (w_bypass) begin
              r_rdata <= wdata;
              r_rhit  <= 1'b1;
            end else begin
              r_rdata <= w_word[w_raddr[gi]];
              r_rhit  <= w_flag[w_raddr[gi]];
            end
          end
        end
      end

      assign w_rdata[gi]  = r_rdata;
      assign w_rvalid[gi] = r_rvalid;
      assign w_rhit[gi]   = r_rhit;
    end
  endgenerate

  assign rdata_a  = w_rdata[0];
  assign rvalid_a = w_rvalid[0];
  assign rhit_a   = w_rhit[0];
  assign rdata_b  = w_rdata[1];
  assign rvalid_b = w_rvalid[1];
  assign rhit_b   = w_rhit[1];

endmodule

// File: doc/dec_reg_file.md
Name: dec_reg_file

Overview:
- Parametrised register file with a one-hot decoded write select and two independent registered read ports.
- Generalises the 3-to-8 decoder and the async/sync-reset D flip-flop into one storage block of 2^AW words, each WIDTH bits wide.
- Tracks a per-word "written" flag.
- Serves as general-purpose scratch/config storage for datapath blocks in the design.

Parameters:
- WIDTH, 8, data bits per word (>=1).
- AW, 3, address bits; depth NREG = 2^AW words (1..8 supported).
- RESET_VAL, 0, value loaded into every word on reset or sync clear; WIDTH bits.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sclr  input  1  synchronous clear, active-high; sampled on rising clk.
- we  input  1  write enable.
- waddr  input  AW  write address.
- wdata  input  WIDTH  write data.
- wsel  output  2^AW  combinational one-hot write decode.
- re_a  input  1  read request, port A.
- raddr_a  input  AW  read address, port A.
- rdata_a  output  WIDTH  registered read data, port A.
- rvalid_a  output  1  one-cycle pulse: rdata_a updated this cycle.
- rhit_a  output  1  addressed word had been written since last clear (registered with rdata_a).
- re_b, raddr_b, rdata_b, rvalid_b, rhit_b: identical to port A, for port B.

Behaviour:
- Reset (rst_n=0, asynchronous, immediate; no clk edge required):
  - all words = RESET_VAL, all written flags = 0.
  - rdata_a/b = 0, rvalid_a/b = 0, rhit_a/b = 0.
  - Reset mid-operation aborts any pending read; no output glitches to stale data after rst_n deasserts.
- wsel:
  - wsel = we ? (1 << waddr) : 0. Purely combinational, not gated by sclr or rst_n.
  - Exactly one bit set when we=1.
- Priority at each rising edge, rst_n=1: sclr > write/read.
- sclr=1:
  - all words = RESET_VAL, all flags = 0.
  - rdata_a/b = 0, rvalid_a/b = 0, rhit_a/b = 0.
  - we, re_a and re_b are ignored that cycle.
- Write (we=1, sclr=0):
  - word[waddr] <= wdata and flag[waddr] <= 1.
  - Other words unchanged.
  - Rewriting an already-written word is allowed and simply overwrites it.
- Read, port A (re_a=1, sclr=0):
  - rdata_a and rhit_a are registered, latency 1 cycle. rvalid_a = 1 for the cycle following the request edge.
  - Bypass: if we=1 and waddr==raddr_a in the same cycle, rdata_a <= wdata and rhit_a <= 1 (write-through; new data is returned).
  - Otherwise rdata_a <= word[raddr_a] and rhit_a <= flag[raddr_a].
- No read (re_a=0):
  - rdata_a and rhit_a hold their previous values; rvalid_a <= 0.
- Port B: identical to port A and independent of it.
  - Both ports may read the same address in the same cycle; both return the same value, including bypass.
- Back-to-back reads every cycle are supported at full throughput; no stall, no backpressure.
- Address wrap: none. Every AW-bit address is valid; all 2^AW words are implemented.
- No X propagation: all storage is reset, so every read returns a defined value.

Test Plan:
- Reset/readout (WIDTH=8, AW=3, RESET_VAL=8'hA5): assert rst_n=0 mid-cycle -> outputs clear immediately. Release, then read addr 0..7 on port A -> each rdata_a=8'hA5, rhit_a=0, rvalid_a pulses 1 cycle after each request.
- Decode/write: we=1, waddr=0..7 in turn, wdata=8'h10+addr -> wsel = 8'h01, 8'h02, ... 8'h80 in turn. Subsequent port B reads return 8'h10..8'h17 with rhit_b=1. With we=0 -> wsel=8'h00.
- Bypass: word[3]=8'h33; same cycle drive we=1, waddr=3, wdata=8'hC7, re_a=1, raddr_a=3, re_b=1, raddr_b=3 -> next cycle rdata_a=rdata_b=8'hC7, rhit=1. Read of addr 2 in the same cycle returns the old word[2].
- Sync clear priority: after writes, drive sclr=1 together with we=1 (addr 5, 8'hFF) and re_a=1 -> next cycle rdata_a=0, rvalid_a=0, no write occurs. A later read of addr 5 returns RESET_VAL with rhit=0.
- Hold behaviour: read addr 1 (8'h11), then re_a=0 for 4 cycles while writing addr 1 = 8'h99 -> rdata_a stays 8'h11, rvalid_a=0 throughout.
- Parameter sweep: WIDTH=1, AW=1 and WIDTH=32, AW=4 -> repeat the decode, bypass and clear scenarios; wsel width = 2 and 16 respectively.
